// File: rtl/tlb_ptw_arbiter.sv
// Two-requester (itlb/dtlb) arbiter in front of a single page-table walker; one walk in flight.
// Define TLB_PTW_ARB_RR_EN for round-robin arbitration, otherwise dtlb has fixed priority.
module tlb_ptw_arbiter #(
  parameter int VPN_W  = 27,
  parameter int ASID_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              itlb_req_valid_i,
  input  logic [VPN_W-1:0]  itlb_req_vpn_i,
  input  logic [ASID_W-1:0] itlb_req_asid_i,
  input  logic [1:0]        itlb_req_prv_i,
  input  logic              itlb_req_store_i,
  input  logic              itlb_req_fetch_i,
  output logic              itlb_grant_o,
  output logic              itlb_resp_valid_o,
  output logic              itlb_cancel_o,
  input  logic              dtlb_req_valid_i,
  input  logic [VPN_W-1:0]  dtlb_req_vpn_i,
  input  logic [ASID_W-1:0] dtlb_req_asid_i,
  input  logic [1:0]        dtlb_req_prv_i,
  input  logic              dtlb_req_store_i,
  input  logic              dtlb_req_fetch_i,
  output logic              dtlb_grant_o,
  output logic              dtlb_resp_valid_o,
  output logic              dtlb_cancel_o,
  output logic              ptw_req_valid_o,
  output logic [VPN_W-1:0]  ptw_req_vpn_o,
  output logic [ASID_W-1:0] ptw_req_asid_o,
  output logic [1:0]        ptw_req_prv_o,
  output logic              ptw_req_store_o,
  output logic              ptw_req_fetch_o,
  input  logic              ptw_ready_i,
  input  logic              ptw_resp_valid_i,
  input  logic              invalidate_i,
  output logic              busy_o,
  output logic              owner_o
);
  typedef struct packed {
    logic [VPN_W-1:0]  vpn;
    logic [ASID_W-1:0] asid;
    logic [1:0]        prv;
    logic              store;
    logic              fetch;
  } req_t;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DRAIN} state_t;

  state_t state;
  req_t   req_q;
  logic   owner_q;
  req_t   itlb_req, dtlb_req, win_req, out_req;
  logic   win_dtlb, grant, resp_fire, cancel_fire;

  assign itlb_req = '{vpn: itlb_req_vpn_i, asid: itlb_req_asid_i, prv: itlb_req_prv_i,
                      store: itlb_req_store_i, fetch: itlb_req_fetch_i};
  assign dtlb_req = '{vpn: dtlb_req_vpn_i, asid: dtlb_req_asid_i, prv: dtlb_req_prv_i,
                      store: dtlb_req_store_i, fetch: dtlb_req_fetch_i};

`ifdef TLB_PTW_ARB_RR_EN
  // rr_ptr=0 favours dtlb; it flips toward whichever side was not just granted.
  logic rr_ptr;
  assign win_dtlb = dtlb_req_valid_i && (!itlb_req_valid_i || !rr_ptr);

  always_ff @(posedge clk_i) begin
    if (rst_i)      rr_ptr <= 1'b0;
    else if (grant) rr_ptr <= win_dtlb;
  end
`else
  assign win_dtlb = dtlb_req_valid_i;
`endif

  assign win_req = win_dtlb ? dtlb_req : itlb_req;

  // Outputs are masked during reset so an in-flight walk cannot leak a pulse.
  assign grant       = !rst_i && (state == IDLE) && (itlb_req_valid_i || dtlb_req_valid_i);
  assign resp_fire   = !rst_i && (state == WAIT) && ptw_resp_valid_i;
  assign cancel_fire = !rst_i && invalidate_i &&
                       ((state == SEND) || ((state == WAIT) && !ptw_resp_valid_i));

  assign itlb_grant_o      = grant && !win_dtlb;
  assign dtlb_grant_o      = grant &&  win_dtlb;
  assign itlb_resp_valid_o = resp_fire && !owner_q;
  assign dtlb_resp_valid_o = resp_fire &&  owner_q;
  assign itlb_cancel_o     = cancel_fire && !owner_q;
  assign dtlb_cancel_o     = cancel_fire &&  owner_q;

  assign ptw_req_valid_o = (state == SEND);
  assign out_req         = (state == SEND) ? req_q : '0;
  assign ptw_req_vpn_o   = out_req.vpn;
  assign ptw_req_asid_o  = out_req.asid;
  assign ptw_req_prv_o   = out_req.prv;
  assign ptw_req_store_o = out_req.store;
  assign ptw_req_fetch_o = out_req.fetch;
  assign busy_o          = (state != IDLE);
  assign owner_o         = owner_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      owner_q <= 1'b0;
      req_q   <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          req_q   <= win_req;
          owner_q <= win_dtlb;
          state   <= SEND;
        end
        SEND: begin
          if (ptw_ready_i)       state <= invalidate_i ? DRAIN : WAIT;
          else if (invalidate_i) state <= IDLE;
        end
        WAIT: begin
          if (ptw_resp_valid_i)  state <= IDLE;
          else if (invalidate_i) state <= DRAIN;
        end
        DRAIN: if (ptw_resp_valid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
